// File: rtl/irig_b_encoder_if.sv
// Signal bundle between an IRIG-B time source and the DCLS encoder:
// time fields and control in, serial code and framing status out.
interface irig_b_encoder_if;
    logic       enable;
    logic       time_load;
    logic [3:0] second_units;
    logic [2:0] second_tens;
    logic [3:0] minute_units;
    logic [2:0] minute_tens;
    logic [3:0] hour_units;
    logic [1:0] hour_tens;
    logic [3:0] day_units;
    logic [3:0] day_tens;
    logic [1:0] day_hunds;
    logic [3:0] year_units;
    logic [3:0] year_tens;
    logic       bcode_out;
    logic       frame_start;
    logic       busy;

    modport master (
        output enable, time_load,
        output second_units, second_tens, minute_units, minute_tens,
        output hour_units, hour_tens, day_units, day_tens, day_hunds,
        output year_units, year_tens,
        input  bcode_out, frame_start, busy
    );

    modport slave (
        input  enable, time_load,
        input  second_units, second_tens, minute_units, minute_tens,
        input  hour_units, hour_tens, day_units, day_tens, day_hunds,
        input  year_units, year_tens,
        output bcode_out, frame_start, busy
    );
endinterface

// File: rtl/irig_b_encoder.sv
// IRIG-B000 DCLS encoder: one 100-bit BCD time-of-year frame per second,
// symbol timing from a millisecond prescaler, all outputs registered.
module irig_b_encoder #(
    parameter int CLKS_PER_MS = 50000
) (
    input logic             clk,
    input logic             rst,
    irig_b_encoder_if.slave bus
);

    localparam int MS_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(CLKS_PER_MS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] su;
        logic [2:0] st;
        logic [3:0] mu;
        logic [2:0] mt;
        logic [3:0] hu;
        logic [1:0] ht;
        logic [3:0] du;
        logic [3:0] dt;
        logic [1:0] dh;
        logic [3:0] yu;
        logic [3:0] yt;
    } time_fields_t;

    function automatic logic [99:0] marker_mask();
        logic [99:0] m;
        m = 100'd0;
        for (int i = 0; i < 100; i++) begin
            m[i] = (i == 0) || ((i % 10) == 9);
        end
        return m;
    endfunction

    localparam logic [99:0] MARKERS = marker_mask();

    // Data bits only; marker positions and unused slots stay 0 here.
    function automatic logic [99:0] build_frame(input time_fields_t t);
        logic [99:0] f;
        f        = 100'd0;
        f[4:1]   = t.su;
        f[8:6]   = t.st;
        f[13:10] = t.mu;
        f[17:15] = t.mt;
        f[23:20] = t.hu;
        f[26:25] = t.ht;
        f[33:30] = t.du;
        f[38:35] = t.dt;
        f[41:40] = t.dh;
        f[53:50] = t.yu;
        f[58:55] = t.yt;
        return f;
    endfunction

    function automatic logic [3:0] high_ms(input logic marker, input logic data);
        logic [3:0] h;
        if (marker) begin
            h = 4'd8;
        end else if (data) begin
            h = 4'd5;
        end else begin
            h = 4'd2;
        end
        return h;
    endfunction

    state_t         state_r;
    logic [MS_W-1:0] ms_cnt_r;
    logic [3:0]     sub_ms_r;
    logic [6:0]     bit_idx_r;
    time_fields_t   shadow_r;
    logic [99:0]    frame_r;
    logic           bcode_r;
    logic           frame_start_r;
    logic           busy_r;

    time_fields_t    fields_in_s;
    logic [MS_W-1:0] ms_nxt_s;
    logic [3:0]      sub_nxt_s;
    logic [6:0]      bit_nxt_s;
    logic            frame_end_s;
    logic            sym_high_s;

    // Gather the live time inputs into one record.
    always_comb begin
        fields_in_s    = '{default: 1'b0};
        fields_in_s.su = bus.second_units;
        fields_in_s.st = bus.second_tens;
        fields_in_s.mu = bus.minute_units;
        fields_in_s.mt = bus.minute_tens;
        fields_in_s.hu = bus.hour_units;
        fields_in_s.ht = bus.hour_tens;
        fields_in_s.du = bus.day_units;
        fields_in_s.dt = bus.day_tens;
        fields_in_s.dh = bus.day_hunds;
        fields_in_s.yu = bus.year_units;
        fields_in_s.yt = bus.year_tens;
    end

    // Next position in the ms / sub-ms / bit chain and the symbol level there.
    always_comb begin
        ms_nxt_s  = ms_cnt_r;
        sub_nxt_s = sub_ms_r;
        bit_nxt_s = bit_idx_r;
        if (ms_cnt_r == MS_LAST) begin
            ms_nxt_s = {MS_W{1'b0}};
            if (sub_ms_r == 4'd9) begin
                sub_nxt_s = 4'd0;
                if (bit_idx_r == 7'd99) begin
                    bit_nxt_s = 7'd0;
                end else begin
                    bit_nxt_s = bit_idx_r + 7'd1;
                end
            end else begin
                sub_nxt_s = sub_ms_r + 4'd1;
            end
        end else begin
            ms_nxt_s = ms_cnt_r + MS_W'(1);
        end
        frame_end_s = (ms_cnt_r == MS_LAST) && (sub_ms_r == 4'd9) && (bit_idx_r == 7'd99);
        sym_high_s  = sub_nxt_s < high_ms(MARKERS[bit_nxt_s], frame_r[bit_nxt_s]);
    end

    // Shadow capture and per-frame snapshot. The snapshot is taken while
    // frame_start is high; Pr carries no data, so a strobe in that same
    // cycle still reaches this frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= '{default: 1'b0};
            frame_r  <= 100'd0;
        end else begin
            if (bus.time_load) begin
                shadow_r <= fields_in_s;
            end
            if (frame_start_r) begin
                frame_r <= build_frame(bus.time_load ? fields_in_s : shadow_r);
            end
        end
    end

    // Transmit state machine with registered, mutually aligned outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            ms_cnt_r      <= {MS_W{1'b0}};
            sub_ms_r      <= 4'd0;
            bit_idx_r     <= 7'd0;
            bcode_r       <= 1'b0;
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ms_cnt_r  <= {MS_W{1'b0}};
                    sub_ms_r  <= 4'd0;
                    bit_idx_r <= 7'd0;
                    if (bus.enable) begin
                        state_r       <= RUN;
                        bcode_r       <= 1'b1;
                        frame_start_r <= 1'b1;
                        busy_r        <= 1'b1;
                    end else begin
                        bcode_r       <= 1'b0;
                        frame_start_r <= 1'b0;
                        busy_r        <= 1'b0;
                    end
                end
                RUN: begin
                    ms_cnt_r  <= ms_nxt_s;
                    sub_ms_r  <= sub_nxt_s;
                    bit_idx_r <= bit_nxt_s;
                    if (frame_end_s && !bus.enable) begin
                        state_r       <= IDLE;
                        bcode_r       <= 1'b0;
                        frame_start_r <= 1'b0;
                        busy_r        <= 1'b0;
                    end else begin
                        bcode_r       <= sym_high_s;
                        frame_start_r <= frame_end_s;
                        busy_r        <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    ms_cnt_r      <= {MS_W{1'b0}};
                    sub_ms_r      <= 4'd0;
                    bit_idx_r     <= 7'd0;
                    bcode_r       <= 1'b0;
                    frame_start_r <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bcode_out   = bcode_r;
    assign bus.frame_start = frame_start_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_irig_b_encoder.sv
// Directed bench for irig_b_encoder at CLKS_PER_MS = 4 (40-cycle bits, 4000-cycle frames).
module tb_irig_b_encoder;

    localparam int CPM   = 4;
    localparam int BITC  = 10 * CPM;
    localparam int FRAMC = 100 * BITC;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   hi[100];
    int   stray_fs;
    int   busy_lo;
    int   shape_err;
    int   nz;

    irig_b_encoder_if bus ();

    irig_b_encoder #(.CLKS_PER_MS(CPM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Independent frame model: expected data bit per frame position.
    function automatic logic [99:0] exp_frame(
        input logic [3:0] su, input logic [2:0] st, input logic [3:0] mu, input logic [2:0] mt,
        input logic [3:0] hu, input logic [1:0] ht, input logic [3:0] du, input logic [3:0] dt,
        input logic [1:0] dh, input logic [3:0] yu, input logic [3:0] yt);
        logic [99:0] f;
        f = 100'd0;
        for (int i = 0; i < 4; i++) begin
            f[1 + i]  = su[i];
            f[10 + i] = mu[i];
            f[20 + i] = hu[i];
            f[30 + i] = du[i];
            f[35 + i] = dt[i];
            f[50 + i] = yu[i];
            f[55 + i] = yt[i];
        end
        for (int i = 0; i < 3; i++) begin
            f[6 + i]  = st[i];
            f[15 + i] = mt[i];
        end
        for (int i = 0; i < 2; i++) begin
            f[25 + i] = ht[i];
            f[40 + i] = dh[i];
        end
        return f;
    endfunction

    function automatic int exp_hi(input int b, input logic [99:0] f);
        if (b == 0 || (b % 10) == 9) return 8 * CPM;
        return f[b] ? 5 * CPM : 2 * CPM;
    endfunction

    // Observe one whole frame from its cycle 0, optionally loading seconds or dropping enable.
    task automatic run_frame(input int load_cyc, input logic [3:0] ld_su, input logic [2:0] ld_st,
                             input int drop_cyc);
        for (int b = 0; b < 100; b++) hi[b] = 0;
        stray_fs  = 0;
        busy_lo   = 0;
        shape_err = 0;
        for (int c = 0; c < FRAMC; c++) begin
            if (bus.bcode_out === 1'b1) begin
                if (hi[c / BITC] != (c % BITC)) shape_err++;
                hi[c / BITC]++;
            end
            if (c > 0 && bus.frame_start !== 1'b0) stray_fs++;
            if (bus.busy !== 1'b1) busy_lo++;
            if (c == load_cyc) begin
                bus.second_units = ld_su;
                bus.second_tens  = ld_st;
                bus.time_load    = 1'b1;
            end
            if (c == drop_cyc) bus.enable = 1'b0;
            tick();
            bus.time_load = 1'b0;
        end
    endtask

    task automatic check_frame(input string name, input logic [99:0] f);
        for (int b = 0; b < 100; b++) begin
            check($sformatf("%s_bit%0d_high", name, b), hi[b], exp_hi(b, f));
        end
        check({name, "_stray_frame_start"}, stray_fs, 0);
        check({name, "_busy_low"}, busy_lo, 0);
        check({name, "_symbol_shape"}, shape_err, 0);
    endtask

    int pl_bit[17] = '{1, 2, 3, 4, 6, 7, 8, 20, 21, 22, 23, 40, 41, 55, 56, 57, 58};
    int pl_hi[17]  = '{8, 20, 20, 8, 20, 8, 20, 8, 20, 8, 8, 20, 8, 8, 20, 8, 8};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.time_load = 1'b0;
        bus.second_units = 4'd0; bus.second_tens = 3'd0;
        bus.minute_units = 4'd0; bus.minute_tens = 3'd0;
        bus.hour_units = 4'd0;   bus.hour_tens = 2'd0;
        bus.day_units = 4'd0;    bus.day_tens = 4'd0; bus.day_hunds = 2'd0;
        bus.year_units = 4'd0;   bus.year_tens = 4'd0;

        // Reset and idle
        tick(); tick(); tick();
        check("rst_bcode", bus.bcode_out, 1'b0);
        check("rst_frame_start", bus.frame_start, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        nz = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.bcode_out !== 1'b0 || bus.frame_start !== 1'b0 || bus.busy !== 1'b0) nz++;
        end
        check("idle_outputs_quiet", nz, 0);

        // Load 12:34:56 day 123 year 23, then start
        bus.second_units = 4'd6; bus.second_tens = 3'd5;
        bus.minute_units = 4'd4; bus.minute_tens = 3'd3;
        bus.hour_units = 4'd2;   bus.hour_tens = 2'd1;
        bus.day_units = 4'd3;    bus.day_tens = 4'd2; bus.day_hunds = 2'd1;
        bus.year_units = 4'd3;   bus.year_tens = 4'd2;
        bus.time_load = 1'b1;
        tick();
        bus.time_load = 1'b0;
        tick();
        check("idle_after_load_busy", bus.busy, 1'b0);
        bus.enable = 1'b1;
        tick();
        check("start_frame_start", bus.frame_start, 1'b1);
        check("start_busy", bus.busy, 1'b1);
        check("start_bcode", bus.bcode_out, 1'b1);

        run_frame(-1, 4'd0, 3'd0, -1);
        check_frame("f1", exp_frame(4'd6, 3'd5, 4'd4, 3'd3, 4'd2, 2'd1, 4'd3, 4'd2, 2'd1, 4'd3, 4'd2));
        for (int i = 0; i < 17; i++) begin
            check($sformatf("f1_plan_bit%0d", pl_bit[i]), hi[pl_bit[i]], pl_hi[i]);
        end
        check("f1_p9_high", hi[99], 32);
        check("boundary_frame_start_4000", bus.frame_start, 1'b1);
        check("boundary_pr_high", bus.bcode_out, 1'b1);

        // Mid-frame load of 57: this frame keeps 56
        run_frame(1000, 4'd7, 3'd5, -1);
        check_frame("f2", exp_frame(4'd6, 3'd5, 4'd4, 3'd3, 4'd2, 2'd1, 4'd3, 4'd2, 2'd1, 4'd3, 4'd2));
        check("f2_pr_high", hi[0], 32);
        check("f3_frame_start", bus.frame_start, 1'b1);

        run_frame(-1, 4'd0, 3'd0, -1);
        check_frame("f3", exp_frame(4'd7, 3'd5, 4'd4, 3'd3, 4'd2, 2'd1, 4'd3, 4'd2, 2'd1, 4'd3, 4'd2));
        check("f4_frame_start", bus.frame_start, 1'b1);

        // Load 58 on the frame-start cycle, drop enable at bit 40
        run_frame(0, 4'd8, 3'd5, 40 * BITC);
        check_frame("f4", exp_frame(4'd8, 3'd5, 4'd4, 3'd3, 4'd2, 2'd1, 4'd3, 4'd2, 2'd1, 4'd3, 4'd2));
        check("stop_busy", bus.busy, 1'b0);
        check("stop_bcode", bus.bcode_out, 1'b0);
        check("stop_frame_start", bus.frame_start, 1'b0);
        nz = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.bcode_out !== 1'b0 || bus.frame_start !== 1'b0 || bus.busy !== 1'b0) nz++;
        end
        check("stopped_quiet", nz, 0);

        // Reset at bit 30
        bus.enable = 1'b1;
        tick();
        check("restart_frame_start", bus.frame_start, 1'b1);
        for (int i = 0; i < 30 * BITC; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst_bcode", bus.bcode_out, 1'b0);
        check("midrst_frame_start", bus.frame_start, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        tick();
        check("midrst_hold_busy", bus.busy, 1'b0);
        rst = 1'b0;
        tick();
        check("post_rst_frame_start", bus.frame_start, 1'b1);
        check("post_rst_busy", bus.busy, 1'b1);
        check("post_rst_bcode", bus.bcode_out, 1'b1);
        run_frame(-1, 4'd0, 3'd0, -1);
        check_frame("f5", 100'd0);
        check("f6_frame_start", bus.frame_start, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
